// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl: drives one dot-product through an external signed MAC.
// Clears the accumulator, streams operand pairs, drains the MAC pipeline,
// pulses finalize and returns the captured result over valid/ready.
// Every output is a flop so the MAC and the result consumer see clean edges.
// DRAIN must be at least 1 and TIMEOUT at least 2.
module mac_seq_ctrl #(
  parameter int LEN_W   = 8,
  parameter int DRAIN   = 8,
  parameter int TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [15:0]      op_a,
  input  logic [15:0]      op_b,
  output logic             mac_rst,
  output logic             mac_en,
  output logic             mac_finalize,
  output logic [15:0]      mac_a,
  output logic [15:0]      mac_b,
  input  logic [31:0]      mac_out,
  input  logic             mac_out_valid,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic             res_err,
  output logic             busy
);

  // One shared down-counter serves both the drain wait and the result timeout.
  localparam int TMR_MAX = (DRAIN > TIMEOUT) ? DRAIN : TIMEOUT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] TMR_ZERO   = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(32'd1);
  localparam logic [TMR_W-1:0] DRAIN_LOAD = TMR_W'(DRAIN - 1);
  // FINAL already counts as the first cycle of the result window.
  localparam logic [TMR_W-1:0] WAIT_LOAD  = TMR_W'(TIMEOUT - 2);
  localparam logic [LEN_W-1:0] LEN_ZERO   = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE    = LEN_W'(32'd1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_FINAL = 3'd4,
    S_WAIT  = 3'd5,
    S_HOLD  = 3'd6
  } state_t;

  state_t           state_r;
  state_t           state_nx_s;
  logic [LEN_W-1:0] cnt_r;
  logic [LEN_W-1:0] cnt_nx_s;
  logic [TMR_W-1:0] tmr_r;
  logic [TMR_W-1:0] tmr_nx_s;
  logic             beat_s;
  logic             cap_s;
  logic [31:0]      cap_data_s;
  logic             cap_err_s;

  // op_ready is a flop that is high exactly while in FEED.
  assign beat_s = op_valid & op_ready;

  // State, beat counter and timer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE;
      cnt_r   <= LEN_ZERO;
      tmr_r   <= TMR_ZERO;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      tmr_r   <= tmr_nx_s;
    end
  end

  // Next-state, counter updates and result capture decision.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    tmr_nx_s   = tmr_r;
    cap_s      = 1'b0;
    cap_data_s = 32'h0000_0000;
    cap_err_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          cnt_nx_s = cmd_len;
          if (cmd_len == LEN_ZERO) begin
            // Empty vector: result is zero and the MAC is never touched.
            state_nx_s = S_HOLD;
            cap_s      = 1'b1;
          end else begin
            state_nx_s = S_CLEAR;
          end
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_CLEAR: begin
        state_nx_s = S_FEED;
      end
      S_FEED: begin
        if (beat_s) begin
          cnt_nx_s = cnt_r - LEN_ONE;
          if (cnt_r == LEN_ONE) begin
            state_nx_s = S_DRAIN;
            tmr_nx_s   = DRAIN_LOAD;
          end else begin
            state_nx_s = S_FEED;
          end
        end else begin
          state_nx_s = S_FEED;
        end
      end
      S_DRAIN: begin
        if (tmr_r == TMR_ZERO) begin
          state_nx_s = S_FINAL;
        end else begin
          tmr_nx_s = tmr_r - TMR_ONE;
        end
      end
      S_FINAL: begin
        if (mac_out_valid) begin
          state_nx_s = S_HOLD;
          cap_s      = 1'b1;
          cap_data_s = mac_out;
        end else begin
          state_nx_s = S_WAIT;
          tmr_nx_s   = WAIT_LOAD;
        end
      end
      S_WAIT: begin
        if (mac_out_valid) begin
          state_nx_s = S_HOLD;
          cap_s      = 1'b1;
          cap_data_s = mac_out;
        end else if (tmr_r == TMR_ZERO) begin
          state_nx_s = S_HOLD;
          cap_s      = 1'b1;
          cap_err_s  = 1'b1;
        end else begin
          tmr_nx_s = tmr_r - TMR_ONE;
        end
      end
      S_HOLD: begin
        if (res_valid && res_ready) begin
          state_nx_s = S_IDLE;
        end else begin
          state_nx_s = S_HOLD;
        end
      end
      default: begin
        state_nx_s = S_IDLE;
      end
    endcase
  end

  // Registered outputs, decoded from the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_ready    <= 1'b0;
      op_ready     <= 1'b0;
      mac_rst      <= 1'b1;
      mac_en       <= 1'b0;
      mac_finalize <= 1'b0;
      mac_a        <= 16'h0000;
      mac_b        <= 16'h0000;
      res_valid    <= 1'b0;
      res_data     <= 32'h0000_0000;
      res_err      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      cmd_ready    <= (state_nx_s == S_IDLE);
      op_ready     <= (state_nx_s == S_FEED);
      mac_rst      <= (state_nx_s == S_CLEAR);
      mac_finalize <= (state_nx_s == S_FINAL);
      res_valid    <= (state_nx_s == S_HOLD);
      busy         <= (state_nx_s != S_IDLE);
      mac_en       <= beat_s;
      mac_a        <= beat_s ? op_a : 16'h0000;
      mac_b        <= beat_s ? op_b : 16'h0000;
      if (cap_s) begin
        res_data <= cap_data_s;
        res_err  <= cap_err_s;
      end
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Testbench for mac_seq_ctrl: table of single commands plus hand-written
// backpressure, timeout and reset-abort sequences against a small MAC model.
module tb_mac_seq_ctrl;
  localparam int LEN_W   = 8;
  localparam int DRAIN   = 8;
  localparam int TIMEOUT = 32;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [LEN_W-1:0]   cmd_len = '0;
  logic               op_valid = 1'b0;
  logic               op_ready;
  logic signed [15:0] op_a = '0;
  logic signed [15:0] op_b = '0;
  logic               mac_rst;
  logic               mac_en;
  logic               mac_finalize;
  logic signed [15:0] mac_a;
  logic signed [15:0] mac_b;
  logic signed [31:0] mac_out;
  logic               mac_out_valid;
  logic               res_valid;
  logic               res_ready = 1'b0;
  logic [31:0]        res_data;
  logic               res_err;
  logic               busy;

  always #5 clk = ~clk;

  mac_seq_ctrl #(.LEN_W(LEN_W), .DRAIN(DRAIN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
    .mac_rst(mac_rst), .mac_en(mac_en), .mac_finalize(mac_finalize),
    .mac_a(mac_a), .mac_b(mac_b), .mac_out(mac_out), .mac_out_valid(mac_out_valid),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_err(res_err), .busy(busy)
  );

  // MAC model: sync clear, accumulate on enable, result one cycle after
  // finalize (or in the finalize cycle itself when fast is set).
  logic signed [31:0] acc = '0;
  logic signed [31:0] out_r = '0;
  logic               vld_r = 1'b0;
  logic               mute = 1'b0;
  logic               fast = 1'b0;
  always @(posedge clk) begin
    if (mac_rst) acc <= 32'sd0;
    else if (mac_en) acc <= acc + mac_a * mac_b;
    vld_r <= mac_finalize & ~mute & ~fast;
    out_r <= acc;
  end
  assign mac_out_valid = fast ? (mac_finalize & ~mute) : vld_r;
  assign mac_out       = fast ? acc : out_r;

  // Activity monitor; cyc is the number of rising edges seen so far.
  int   cyc = 0, en_total = 0, rst_total = 0, fin_total = 0, en_runs = 0;
  int   en_first = 0, en_last = 0, fin_cyc = 0;
  logic en_prev = 1'b0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      if (mac_en) begin
        en_total <= en_total + 1;
        en_last  <= cyc;
      end
      if (mac_en && !en_prev) begin
        en_runs  <= en_runs + 1;
        en_first <= cyc;
      end
      if (mac_rst) rst_total <= rst_total + 1;
      if (mac_finalize) begin
        fin_total <= fin_total + 1;
        fin_cyc   <= cyc;
      end
    end
    en_prev <= mac_en;
  end

  typedef struct packed {
    logic [7:0]       len;
    logic [2:0][15:0] a;
    logic [2:0][15:0] b;
    logic [3:0]       gap;
    logic             fast;
    logic [31:0]      exp_data;
    logic [7:0]       exp_runs;
  } vec_t;

  int checks = 0;
  int fails  = 0;

  function automatic vec_t mk(input int len, input int a0, input int b0,
                              input int a1, input int b1, input int a2, input int b2,
                              input int gap, input bit fst, input int exp, input int runs);
    vec_t v;
    v.len = 8'(len);
    v.a[0] = 16'(a0); v.b[0] = 16'(b0);
    v.a[1] = 16'(a1); v.b[1] = 16'(b1);
    v.a[2] = 16'(a2); v.b[2] = 16'(b2);
    v.gap = 4'(gap);
    v.fast = fst;
    v.exp_data = 32'(exp);
    v.exp_runs = 8'(runs);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int len, output int a_edge);
    int n;
    n = 0;
    cmd_len = LEN_W'(len);
    cmd_valid = 1'b1;
    while (!cmd_ready && n < 100) begin tick(); n++; end
    chk("cmd_ready_wait", int'(n < 100), 1);
    tick();
    a_edge = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic feed(input vec_t v);
    int n;
    for (int i = 0; i < int'(v.len); i++) begin
      op_valid = 1'b1;
      op_a = v.a[i % 3];
      op_b = v.b[i % 3];
      n = 0;
      while (!op_ready && n < 50) begin tick(); n++; end
      chk("op_ready_wait", int'(n < 50), 1);
      tick();
      op_valid = 1'b0;
      op_a = '0;
      op_b = '0;
      for (int g = 0; g < int'(v.gap) && i < int'(v.len) - 1; g++) tick();
    end
  endtask

  task automatic collect(output int data, output int err, output int rlab);
    int n;
    n = 0;
    while (!res_valid && n < 400) begin tick(); n++; end
    chk("res_valid_wait", int'(n < 400), 1);
    data = int'($signed(res_data));
    err  = int'(res_err);
    rlab = cyc;
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic do_cmd(input vec_t v, input int idx);
    int e0, r0, f0, u0, ae, d, e, rl, n;
    e0 = en_total; r0 = rst_total; f0 = fin_total; u0 = en_runs;
    n = int'(v.len);
    fast = v.fast;
    issue(n, ae);
    feed(v);
    collect(d, e, rl);
    chk($sformatf("v%0d res_data", idx), d, int'($signed(v.exp_data)));
    chk($sformatf("v%0d res_err", idx), e, 0);
    chk($sformatf("v%0d en_cycles", idx), en_total - e0, n);
    chk($sformatf("v%0d en_runs", idx), en_runs - u0, int'(v.exp_runs));
    chk($sformatf("v%0d mac_rst_pulses", idx), rst_total - r0, (n != 0) ? 1 : 0);
    chk($sformatf("v%0d finalize_pulses", idx), fin_total - f0, (n != 0) ? 1 : 0);
    if (n != 0) begin
      chk($sformatf("v%0d res_after_fin", idx), rl - fin_cyc, v.fast ? 1 : 2);
      if (v.gap == 4'd0) begin
        // Cycle k after acceptance edge ae is monitor label ae + k - 1.
        chk($sformatf("v%0d en_first_cycle", idx), en_first - ae + 1, 3);
        chk($sformatf("v%0d en_last_cycle", idx), en_last - ae + 1, n + 2);
        chk($sformatf("v%0d fin_cycle", idx), fin_cyc - ae + 1, n + DRAIN + 2);
      end
    end
    handshake();
    fast = 1'b0;
  endtask

  vec_t tbl [0:5];

  initial begin
    int ae, d, e, rl, f0;
    tbl[0] = mk(3, 10, 5, 6, 7, 3, 4, 0, 1'b0, 104, 1);
    tbl[1] = mk(2, -3, 7, 2, -8, 0, 0, 2, 1'b0, -37, 2);
    tbl[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 0, 0);
    tbl[3] = mk(1, -32768, -32768, 0, 0, 0, 0, 0, 1'b0, 1073741824, 1);
    tbl[4] = mk(3, 100, -200, -7, -9, 32767, 2, 0, 1'b1, 45597, 1);
    tbl[5] = mk(255, 1, 1, 2, 2, 3, 3, 0, 1'b0, 1190, 1);

    // Reset values while rst is low.
    #1 rst = 1'b0;
    #1;
    chk("rst mac_rst", int'(mac_rst), 1);
    chk("rst cmd_ready", int'(cmd_ready), 0);
    chk("rst op_ready", int'(op_ready), 0);
    chk("rst mac_en", int'(mac_en), 0);
    chk("rst finalize", int'(mac_finalize), 0);
    chk("rst res_valid", int'(res_valid), 0);
    chk("rst res_data", int'(res_data), 0);
    chk("rst busy", int'(busy), 0);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("post_rst mac_rst", int'(mac_rst), 0);
    chk("post_rst cmd_ready", int'(cmd_ready), 1);

    for (int i = 0; i < 6; i++) do_cmd(tbl[i], i);

    // Backpressure: result held and no new command taken until handshake.
    issue(1, ae);
    feed(mk(1, 5, 6, 0, 0, 0, 0, 0, 1'b0, 30, 1));
    collect(d, e, rl);
    chk("bp res_data", d, 30);
    cmd_len = 8'd2;
    cmd_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp res_data stable", int'(res_data), 30);
      chk("bp res_valid", int'(res_valid), 1);
      chk("bp cmd_ready", int'(cmd_ready), 0);
    end
    handshake();
    chk("bp cmd_ready after handshake", int'(cmd_ready), 1);
    tick();
    chk("bp accepted busy", int'(busy), 1);
    chk("bp accepted cmd_ready", int'(cmd_ready), 0);
    cmd_valid = 1'b0;
    feed(mk(2, 1, 1, 1, 1, 0, 0, 0, 1'b0, 2, 1));
    collect(d, e, rl);
    chk("bp second res_data", d, 2);
    handshake();

    // Timeout: the MAC never answers.
    mute = 1'b1;
    f0 = fin_total;
    issue(1, ae);
    feed(mk(1, 4, 4, 0, 0, 0, 0, 0, 1'b0, 0, 1));
    collect(d, e, rl);
    chk("to res_err", e, 1);
    chk("to res_data", d, 0);
    chk("to finalize_pulses", fin_total - f0, 1);
    chk("to res_after_fin", rl - fin_cyc, TIMEOUT);
    handshake();
    mute = 1'b0;

    // Reset in the middle of FEED, then a clean command.
    issue(5, ae);
    op_valid = 1'b1;
    op_a = 16'sd9;
    op_b = 16'sd9;
    d = 0;
    while (!op_ready && d < 50) begin tick(); d++; end
    chk("ra op_ready_wait", int'(d < 50), 1);
    tick(); tick();
    rst = 1'b0;
    #1;
    op_valid = 1'b0;
    chk("ra mac_rst", int'(mac_rst), 1);
    chk("ra mac_en", int'(mac_en), 0);
    chk("ra mac_a", int'(mac_a), 0);
    chk("ra op_ready", int'(op_ready), 0);
    chk("ra busy", int'(busy), 0);
    chk("ra cmd_ready", int'(cmd_ready), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("ra hold mac_rst", int'(mac_rst), 1);
      chk("ra hold busy", int'(busy), 0);
    end
    rst = 1'b1;
    tick();
    chk("ra release mac_rst", int'(mac_rst), 0);
    chk("ra release cmd_ready", int'(cmd_ready), 1);
    do_cmd(mk(1, 2, 3, 0, 0, 0, 0, 0, 1'b0, 6, 1), 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mac_seq_ctrl.md
# mac_seq_ctrl

Sequencer for the 16-bit signed MAC datapath (`top`). It accepts a dot-product command with a vector length, streams operand pairs into the MAC, waits out the MAC pipeline, pulses `finalize`, and captures the accumulated result. The result is returned over a valid/ready handshake. It sits between the operand/command source (RISC-V PE side) and one MAC instance; the MAC is owned exclusively by this block.

## Interface
- `LEN_W`, 8: width of vector-length field; max length 2^LEN_W-1
- `DRAIN`, 8: idle cycles after the last MAC beat before `finalize`
- `TIMEOUT`, 32: cycles to wait for `mac_out_valid` after `finalize` before flagging an error
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `cmd_valid` in 1: command request
- `cmd_ready` out 1: high only in IDLE
- `cmd_len` in LEN_W: number of operand pairs
- `op_valid` in 1: operand pair valid
- `op_ready` out 1: high only in FEED
- `op_a`, `op_b` in 16 each: signed operands
- `mac_rst` out 1: active-high reset to MAC
- `mac_en` out 1: MAC enable
- `mac_finalize` out 1: MAC finalize pulse
- `mac_a`, `mac_b` out 16 each: MAC operands, registered
- `mac_out` in 32: MAC accumulated result, signed
- `mac_out_valid` in 1: MAC result strobe
- `res_valid` out 1: result available
- `res_ready` in 1: result consumer ready
- `res_data` out 32: signed result
- `res_err` out 1: result is invalid because of timeout
- `busy` out 1: state != IDLE

## Operation
- States: IDLE, CLEAR, FEED, DRAIN, FINAL, WAIT, HOLD.
- IDLE:
  - `cmd_valid & cmd_ready` latches `cmd_len` into the beat counter.
  - If len=0, go to HOLD with `res_data`=0 and `res_err`=0; the MAC is untouched.
  - Otherwise go to CLEAR.
- CLEAR: `mac_rst`=1 for exactly one cycle, which zeroes the MAC accumulator. Then go to FEED.
- FEED:
  - `op_ready`=1.
  - Each accepted beat (`op_valid & op_ready`) registers `op_a`/`op_b` into `mac_a`/`mac_b`, sets `mac_en`=1 for the next cycle, and decrements the counter.
  - A cycle with no accepted beat drives `mac_en`=0 and `mac_a`/`mac_b`=0 on the next cycle.
  - The accepted beat that brings the counter to 0 moves the block to DRAIN.
- DRAIN:
  - `mac_en`=0 and operands are 0.
  - Counts DRAIN cycles, then goes to FINAL.
- FINAL: `mac_finalize`=1 for one cycle, then go to WAIT.
- WAIT:
  - On `mac_out_valid`, capture `mac_out` into `res_data`, set `res_err`=0, and go to HOLD.
  - If TIMEOUT cycles elapse without `mac_out_valid`, set `res_data`=0 and `res_err`=1, then go to HOLD.
  - `mac_out_valid` is also honoured if it arrives in the FINAL cycle itself.
  - `mac_out_valid` outside FINAL/WAIT is ignored.
- HOLD:
  - `res_valid`=1.
  - `res_data` and `res_err` are stable until `res_valid & res_ready`, then go to IDLE.
- No arithmetic is done here. `res_data` is the MAC 32-bit value passed through unmodified, with overflow semantics owned by the MAC.
- Commands arriving while busy are not accepted (`cmd_ready`=0). The source holds them.

## Timing
- Reset values while `rst`=0:
  - state IDLE
  - `mac_rst`=1, so the MAC is held in reset with the controller
  - `cmd_ready`=0
  - `op_ready`, `mac_en`, `mac_finalize`, `res_valid`, `res_err`, `busy`=0
  - `mac_a`, `mac_b`, `res_data`=0
- The first edge after `rst` rises drops `mac_rst` to 0. `cmd_ready` is 1 from then on while in IDLE.
- Reset asserted mid-operation aborts immediately to the reset values. No result is produced and an in-flight operand is dropped.
- Command accepted at edge 0:
  - CLEAR in cycle 1.
  - FEED from cycle 2.
- With `op_valid` held high and length N:
  - Beats are accepted in cycles 2..N+1.
  - `mac_en` is high in cycles 3..N+2.
  - DRAIN occupies cycles N+2..N+DRAIN+1.
  - `mac_finalize` is high in cycle N+DRAIN+2.
- `res_valid` rises the cycle after `mac_out_valid` is sampled.
- Back-to-back: the next `cmd_ready` occurs the cycle after the result handshake. Minimum idle between commands is one cycle.
- Timeout: `res_valid` rises at the edge TIMEOUT cycles after the FINAL cycle.

## Test plan
- Basic sequence:
  - Stimulus: len=3, pairs (10,5),(6,7),(3,4) back-to-back, `res_ready`=1.
  - Required: `mac_en` high for exactly 3 consecutive cycles, one `mac_finalize` pulse DRAIN cycles later, `res_data`=104, `res_err`=0.
- Signed values with operand gaps:
  - Stimulus: len=2, pairs (-3,7),(2,-8) with `op_valid` low for 2 cycles between the pairs.
  - Required: `mac_en` shows the gap, `res_data`=-37.
- Zero length and back-to-back commands:
  - Stimulus: len=0 command, then immediately len=1 (-32768,-32768).
  - Required: the first result is 0 with no `mac_rst`/`mac_en`/`mac_finalize` activity; the second result is 1073741824 and is preceded by a `mac_rst` pulse.
- Backpressure:
  - Stimulus: `res_ready`=0 for 10 cycles after `res_valid`, with `cmd_valid` high.
  - Required: `res_data` stable, `cmd_ready`=0 throughout; the command is accepted the cycle after the handshake.
- Timeout:
  - Stimulus: force `mac_out_valid`=0.
  - Required: `res_valid` with `res_err`=1 and `res_data`=0 exactly TIMEOUT cycles after `finalize`.
- Reset mid-operation:
  - Stimulus: assert `rst` low during FEED of a len=5 command, release it, then issue len=1 (2,3).
  - Required: all outputs at reset values while `rst` is low, `mac_rst`=1 throughout; the new result is 6, with no residue from the aborted command.
